// File: rtl/uart_pkg.sv
// Shared UART definitions used by both transmitter and receiver:
// FSM state encodings, default bit period and line idle level.
package uart_pkg;
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int   DEF_CLKS_PER_BIT = 868;
  localparam logic IDLE_LEVEL       = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = IDLE,
    S_START  = START,
    S_DATA   = DATA,
    S_PARITY = PARITY,
    S_STOP   = STOP
  } uart_state_t;
endpackage

// File: rtl/uart_tx_ser_if.sv
// Byte-in / serial-out handshake between the typing-test controller and the UART transmitter.
// master = controller side, slave = transmitter side.
interface uart_tx_ser_if;
  logic       tx_go;
  logic [7:0] tx_byte;
  logic       tx_serial;
  logic       tx_active;
  logic       tx_done;
  logic       tx_ready;
  logic       tx_overflow;

  modport master (
    output tx_go, tx_byte,
    input  tx_serial, tx_active, tx_done, tx_ready, tx_overflow
  );

  modport slave (
    input  tx_go, tx_byte,
    output tx_serial, tx_active, tx_done, tx_ready, tx_overflow
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, bit_end is high on the last count.
// restart holds the count at zero so the next bit starts on a clean period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);
  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign bit_end = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || restart || bit_end) count <= '0;
    else                           count <= count + 1'b1;
  end
endmodule

// File: rtl/uart_tx_ser.sv
// UART transmitter with one-byte holding register; 8N1, or 8-bit + parity when UART_TX_PARITY_EN is defined.
// Frame starts the edge after an idle accept; a held byte follows the stop bit with no idle gap.
module uart_tx_ser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int PARITY_ODD   = 0
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_ser_if.slave  bus
);
  uart_state_t state, state_nxt;
  logic        bit_end, accept, stop_end, load;
  logic        hold_full, overflow, serial, par_bit;
  logic [7:0]  shifter, hold, load_byte;
  logic [2:0]  bit_idx;

  // A go is taken whenever the holding slot is free; where it lands depends on state.
  assign accept    = bus.tx_go && !hold_full;
  assign stop_end  = (state == S_STOP) && bit_end;
  assign load      = ((state == S_IDLE) && accept) || (stop_end && (hold_full || accept));
  assign load_byte = hold_full ? hold : bus.tx_byte;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (state == S_IDLE),
    .bit_end (bit_end)
  );

`ifdef UART_TX_PARITY_EN
  localparam uart_state_t AFTER_DATA = S_PARITY;
  localparam logic        PODD_BIT   = PARITY_ODD[0];

  always_ff @(posedge clk) begin
    if (rst)       par_bit <= 1'b0;
    else if (load) par_bit <= (^load_byte) ^ PODD_BIT;
  end
`else
  localparam uart_state_t AFTER_DATA = S_STOP;
  logic unused_parity_cfg;

  assign unused_parity_cfg = ^PARITY_ODD;
  assign par_bit           = IDLE_LEVEL;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    serial    = IDLE_LEVEL;
    unique case (state)
      S_IDLE:   if (accept) state_nxt = S_START;
      S_START: begin
        serial = 1'b0;
        if (bit_end) state_nxt = S_DATA;
      end
      S_DATA: begin
        serial = shifter[0];
        if (bit_end && bit_idx == 3'd7) state_nxt = AFTER_DATA;
      end
      S_PARITY: begin
        serial = par_bit;
        if (bit_end) state_nxt = S_STOP;
      end
      S_STOP:   if (bit_end) state_nxt = (hold_full || accept) ? S_START : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shifter   <= '0;
      bit_idx   <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (bus.tx_go && hold_full) overflow <= 1'b1;
      if (load) begin
        shifter <= load_byte;
        bit_idx <= '0;
      end else if (state == S_DATA && bit_end && bit_idx != 3'd7) begin
        shifter <= shifter >> 1;
        bit_idx <= bit_idx + 3'd1;
      end
      // A go coinciding with the stop-bit end bypasses the holding slot entirely.
      if (stop_end && hold_full) begin
        hold_full <= 1'b0;
      end else if (accept && state != S_IDLE && !stop_end) begin
        hold      <= bus.tx_byte;
        hold_full <= 1'b1;
      end
    end
  end

  assign bus.tx_serial   = serial;
  assign bus.tx_active   = (state != S_IDLE);
  assign bus.tx_done     = stop_end;
  assign bus.tx_ready    = !hold_full;
  assign bus.tx_overflow = overflow;
endmodule

// File: tb/tb_uart_tx_ser.sv
// Bench for uart_tx_ser at CLKS_PER_BIT=4: a serial-line monitor decodes frames against a byte scoreboard,
// a vector table drives go/ready/overflow sequences, and hand sequences cover timing, abort and back-to-back cases.
module tb_uart_tx_ser;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;
  localparam bit PODD  = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_ser_if bus();

  uart_tx_ser #(.CLKS_PER_BIT(CPB), .PARITY_ODD(int'(PODD))) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line monitor: finds the start bit, samples each bit mid-period, checks tx_done placement.
  int         mon_pos = -1;
  int         mon_bit;
  logic [7:0] mon_byte;
  logic       mon_par;
  logic [7:0] exp_b;

  always @(negedge clk) begin
    if (rst) begin
      mon_pos = -1;
    end else begin
      if (mon_pos >= 0) mon_pos++;
      else if (bus.tx_serial == 1'b0) mon_pos = 0;
      check("tx_done_timing", bus.tx_done, (mon_pos == FRAME - 1));
      if (mon_pos >= 0 && (mon_pos % CPB) == CPB / 2) begin
        mon_bit = mon_pos / CPB;
        if (mon_bit == 0) begin
          check("start_bit", bus.tx_serial, 0);
        end else if (mon_bit <= 8) begin
          mon_byte[mon_bit-1] = bus.tx_serial;
        end else if (mon_bit == NBITS - 1) begin
          check("stop_bit", bus.tx_serial, 1);
          check("frame_expected", (sb_q.size() != 0), 1);
          if (sb_q.size() != 0) begin
            exp_b = sb_q.pop_front();
            check("rx_byte", mon_byte, exp_b);
`ifdef UART_TX_PARITY_EN
            check("parity_bit", mon_par, (^exp_b) ^ PODD);
`endif
          end
        end else begin
          mon_par = bus.tx_serial;
        end
      end
      if (mon_pos == FRAME - 1) mon_pos = -1;
    end
  end

  task automatic send(input logic [7:0] b);
    bus.tx_byte = b;
    bus.tx_go   = 1'b1;
    tick();
    bus.tx_go   = 1'b0;
    bus.tx_byte = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || bus.tx_active) && n < 4 * FRAME) begin
      tick();
      n++;
    end
    check("drain_done", (sb_q.size() == 0) && !bus.tx_active, 1);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.tx_go = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sb_q.delete();
    tick();
  endtask

  task automatic run_watch(input int start_c, input int ncyc,
                           output int d1, output int d2, output int act, output int rdy_up);
    d1 = -1; d2 = -1; act = 0; rdy_up = -1;
    for (int c = start_c; c < start_c + ncyc; c++) begin
      if (bus.tx_active) act++;
      if (bus.tx_done) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (bus.tx_ready && rdy_up < 0) rdy_up = c;
      tick();
    end
  endtask

  typedef struct {
    logic [7:0] dat;
    int         gap;
    bit         rst_first;
    bit         acc;
    bit         exp_rdy;
    bit         exp_ovf;
  } vec_t;

  localparam int NV = 7;
  vec_t vt[NV];

  initial begin
    int d1, d2, act, rdy;
    vt[0] = '{8'h0D, 0,  1'b1, 1'b1, 1'b1, 1'b0};
    vt[1] = '{8'h61, 4,  1'b0, 1'b1, 1'b0, 1'b0};
    vt[2] = '{8'h01, 0,  1'b1, 1'b1, 1'b1, 1'b0};
    vt[3] = '{8'h02, 4,  1'b0, 1'b1, 1'b0, 1'b0};
    vt[4] = '{8'h03, 0,  1'b0, 1'b0, 1'b0, 1'b1};
    vt[5] = '{8'hA5, 0,  1'b1, 1'b1, 1'b1, 1'b0};
    vt[6] = '{8'h3C, 10, 1'b0, 1'b1, 1'b0, 1'b0};

    bus.tx_go   = 1'b0;
    bus.tx_byte = 8'h00;
    tick();
    tick();
    check("rst_serial", bus.tx_serial, 1);
    check("rst_active", bus.tx_active, 0);
    check("rst_done", bus.tx_done, 0);
    check("rst_ready", bus.tx_ready, 1);
    check("rst_overflow", bus.tx_overflow, 0);
    rst = 1'b0;
    tick();

    // Single frame from idle: length and tx_done position.
    sb_q.push_back(8'h41);
    send(8'h41);
    run_watch(1, FRAME + 4, d1, d2, act, rdy);
    check("t1_done_cycle", d1, FRAME);
    check("t1_single_done", d2, 32'hFFFF_FFFF);
    check("t1_active_cycles", act, FRAME);
    drain();

    // Second go held during frame 1, released back-to-back at its end.
    sb_q.push_back(8'h0D);
    send(8'h0D);
    repeat (4) tick();
    sb_q.push_back(8'h61);
    send(8'h61);
    check("t2_ready_low", bus.tx_ready, 0);
    run_watch(6, 2 * FRAME, d1, d2, act, rdy);
    check("t2_done1", d1, FRAME);
    check("t2_done2", d2, 2 * FRAME);
    check("t2_ready_back", rdy, FRAME + 1);
    check("t2_no_gap", act, 2 * FRAME - 5);
    drain();

    // Reset mid-frame aborts immediately and the next frame is clean.
    sb_q.push_back(8'hFF);
    send(8'hFF);
    repeat (16) tick();
    rst = 1'b1;
    tick();
    check("t4_serial", bus.tx_serial, 1);
    check("t4_active", bus.tx_active, 0);
    check("t4_ready", bus.tx_ready, 1);
    check("t4_done", bus.tx_done, 0);
    sb_q.delete();
    rst = 1'b0;
    tick();
    check("t4_idle_after", bus.tx_active, 0);
    sb_q.push_back(8'h5A);
    send(8'h5A);
    drain();

    // Go in the same cycle as tx_done with the holding slot empty.
    sb_q.push_back(8'h11);
    send(8'h11);
    repeat (FRAME - 1) tick();
    check("t5_done_now", bus.tx_done, 1);
    check("t5_ready_now", bus.tx_ready, 1);
    sb_q.push_back(8'h22);
    send(8'h22);
    check("t5_active", bus.tx_active, 1);
    check("t5_start_bit", bus.tx_serial, 0);
    check("t5_ready", bus.tx_ready, 1);
    check("t5_overflow", bus.tx_overflow, 0);
    drain();
    check("t5_overflow_end", bus.tx_overflow, 0);

    for (int i = 0; i < NV; i++) begin
      if (vt[i].rst_first) begin
        drain();
        do_reset();
      end
      repeat (vt[i].gap) tick();
      if (vt[i].acc) sb_q.push_back(vt[i].dat);
      send(vt[i].dat);
      check($sformatf("vec%0d_ready", i), bus.tx_ready, vt[i].exp_rdy);
      check($sformatf("vec%0d_overflow", i), bus.tx_overflow, vt[i].exp_ovf);
    end
    drain();

    // Byte 8'h07: even parity bit 1 when enabled; frame length follows the build.
    do_reset();
    check("t6_overflow_cleared", bus.tx_overflow, 0);
    sb_q.push_back(8'h07);
    send(8'h07);
    run_watch(1, FRAME + 4, d1, d2, act, rdy);
    check("t6_done_cycle", d1, FRAME);
    check("t6_active_cycles", act, FRAME);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end
endmodule
